// File: rtl/acq_presum.sv
// ---------------------------------------------------------------------------
// acq_presum -- I/Q presummer and 2-bit sign/magnitude quantizer.
//
// Accumulates `decim` signed samples per block (0 -> 1, clamped to DECIM_MAX).
// It quantizes each block sum to sign and magnitude (|sum| >= thresh_cur).
// Each result is emitted with a one-cycle we_sum strobe.
//
// Optional feature macro: ACQ_PRESUM_AGC_EN
//   defined   -> adaptive threshold, adjusted once per 128-result window
//   undefined -> thresh_cur is loaded from thresh_in only while disabled
//
// Ports
//   rf_clk, rf_resetn      clock, asynchronous active-low reset
//   enable                 run; low discards the partial block
//   decim     [DECIM_W]    samples per block
//   thresh_in [ACC_W]      unsigned magnitude threshold (seed)
//   I_in, Q_in [IN_W]      signed samples, qualified by valid_in
//   I/Q_sum_sig, _mag      registered quantized result (held between strobes)
//   we_sum                 single-cycle result strobe
//   thresh_cur [ACC_W]     threshold currently applied
// ---------------------------------------------------------------------------
module acq_presum #(
    parameter int IN_W      = 8,
    parameter int DECIM_MAX = 16,
    parameter int DECIM_W   = $clog2(DECIM_MAX + 1),
    parameter int ACC_W     = IN_W + $clog2(DECIM_MAX)
) (
    input  logic               rf_clk,
    input  logic               rf_resetn,
    input  logic               enable,
    input  logic [DECIM_W-1:0] decim,
    input  logic [ACC_W-1:0]   thresh_in,
    input  logic [IN_W-1:0]    I_in,
    input  logic [IN_W-1:0]    Q_in,
    input  logic               valid_in,
    output logic               I_sum_sig,
    output logic               I_sum_mag,
    output logic               Q_sum_sig,
    output logic               Q_sum_mag,
    output logic               we_sum,
    output logic [ACC_W-1:0]   thresh_cur
);

    logic [DECIM_W-1:0] count_q, count_d, len_q, len_d;
    logic [ACC_W-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [ACC_W-1:0]   thresh_q, thresh_d;
    logic               i_sig_q, i_sig_d, i_mag_q, i_mag_d;
    logic               q_sig_q, q_sig_d, q_mag_q, q_mag_d;
    logic               we_q, we_d;

    logic [DECIM_W-1:0] eff_decim, cur_len;
    logic [ACC_W-1:0]   sum_i, sum_q, abs_i, abs_q;
    logic               last, mag_i, mag_q;

`ifdef ACQ_PRESUM_AGC_EN
    logic [6:0] win_q, win_d;      // results seen in the current window
    logic [8:0] ones_q, ones_d;    // magnitude-one decisions (max 256)
    logic [8:0] ones_total;
`endif

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        eff_decim = decim;
        if (decim == '0)
            eff_decim = DECIM_W'(1);
        else if (decim > DECIM_W'(DECIM_MAX))
            eff_decim = DECIM_W'(DECIM_MAX);

        // A block's length is fixed when its first sample arrives.
        cur_len = (count_q == '0) ? eff_decim : len_q;

        sum_i = acc_i_q + {{(ACC_W-IN_W){I_in[IN_W-1]}}, I_in};
        sum_q = acc_q_q + {{(ACC_W-IN_W){Q_in[IN_W-1]}}, Q_in};
        // Unsigned magnitude; the most negative sum maps to 2^(ACC_W-1).
        abs_i = sum_i[ACC_W-1] ? (~sum_i + ACC_W'(1)) : sum_i;
        abs_q = sum_q[ACC_W-1] ? (~sum_q + ACC_W'(1)) : sum_q;
        mag_i = (abs_i >= thresh_q);
        mag_q = (abs_q >= thresh_q);

        last = enable && valid_in && (count_q == cur_len - DECIM_W'(1));

        count_d  = count_q;
        len_d    = len_q;
        acc_i_d  = acc_i_q;
        acc_q_d  = acc_q_q;
        thresh_d = thresh_q;
        i_sig_d  = i_sig_q;
        i_mag_d  = i_mag_q;
        q_sig_d  = q_sig_q;
        q_mag_d  = q_mag_q;
        we_d     = last;

`ifdef ACQ_PRESUM_AGC_EN
        win_d      = win_q;
        ones_d     = ones_q;
        ones_total = ones_q + 9'(mag_i) + 9'(mag_q);
`endif

        if (!enable) begin
            count_d  = '0;
            acc_i_d  = '0;
            acc_q_d  = '0;
            thresh_d = thresh_in;
`ifdef ACQ_PRESUM_AGC_EN
            win_d    = '0;
            ones_d   = '0;
`endif
        end else if (valid_in) begin
            if (count_q == '0)
                len_d = eff_decim;
            if (last) begin
                count_d = '0;
                acc_i_d = '0;
                acc_q_d = '0;
                i_sig_d = sum_i[ACC_W-1];
                i_mag_d = mag_i;
                q_sig_d = sum_q[ACC_W-1];
                q_mag_d = mag_q;
`ifdef ACQ_PRESUM_AGC_EN
                win_d = win_q + 7'd1;          // wraps to 0 at window end
                if (win_q == 7'd127) begin
                    ones_d = '0;
                    if (ones_total > 9'd96 && thresh_q != '1)
                        thresh_d = thresh_q + ACC_W'(1);
                    else if (ones_total < 9'd64 && thresh_q > ACC_W'(1))
                        thresh_d = thresh_q - ACC_W'(1);
                end else begin
                    ones_d = ones_total;
                end
`endif
            end else begin
                count_d = count_q + DECIM_W'(1);
                acc_i_d = sum_i;
                acc_q_d = sum_q;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge rf_clk or negedge rf_resetn) begin
        if (!rf_resetn) begin
            count_q  <= '0;
            len_q    <= '0;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            thresh_q <= ACC_W'(1);
            i_sig_q  <= 1'b0;
            i_mag_q  <= 1'b0;
            q_sig_q  <= 1'b0;
            q_mag_q  <= 1'b0;
            we_q     <= 1'b0;
`ifdef ACQ_PRESUM_AGC_EN
            win_q    <= '0;
            ones_q   <= '0;
`endif
        end else begin
            count_q  <= count_d;
            len_q    <= len_d;
            acc_i_q  <= acc_i_d;
            acc_q_q  <= acc_q_d;
            thresh_q <= thresh_d;
            i_sig_q  <= i_sig_d;
            i_mag_q  <= i_mag_d;
            q_sig_q  <= q_sig_d;
            q_mag_q  <= q_mag_d;
            we_q     <= we_d;
`ifdef ACQ_PRESUM_AGC_EN
            win_q    <= win_d;
            ones_q   <= ones_d;
`endif
        end
    end

    assign I_sum_sig  = i_sig_q;
    assign I_sum_mag  = i_mag_q;
    assign Q_sum_sig  = q_sig_q;
    assign Q_sum_mag  = q_mag_q;
    assign we_sum     = we_q;
    assign thresh_cur = thresh_q;

endmodule

// File: tb/tb_acq_presum.sv
// ---------------------------------------------------------------------------
// tb_acq_presum -- directed self-checking bench for acq_presum.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_acq_presum;

    localparam int IN_W    = 8;
    localparam int DECIM_W = 5;
    localparam int ACC_W   = 12;

    logic               rf_clk = 1'b0;
    logic               rf_resetn;
    logic               enable;
    logic [DECIM_W-1:0] decim;
    logic [ACC_W-1:0]   thresh_in;
    logic [IN_W-1:0]    I_in, Q_in;
    logic               valid_in;
    logic               I_sum_sig, I_sum_mag, Q_sum_sig, Q_sum_mag, we_sum;
    logic [ACC_W-1:0]   thresh_cur;

    int n_cmp  = 0;
    int n_fail = 0;
    int first_idx, n_strobe;

    acq_presum dut (
        .rf_clk    (rf_clk),
        .rf_resetn (rf_resetn),
        .enable    (enable),
        .decim     (decim),
        .thresh_in (thresh_in),
        .I_in      (I_in),
        .Q_in      (Q_in),
        .valid_in  (valid_in),
        .I_sum_sig (I_sum_sig),
        .I_sum_mag (I_sum_mag),
        .Q_sum_sig (Q_sum_sig),
        .Q_sum_mag (Q_sum_mag),
        .we_sum    (we_sum),
        .thresh_cur(thresh_cur)
    );

    always #5 rf_clk = ~rf_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rf_clk);
        #1;
    endtask

    // Disabled for one cycle with a new threshold seed, then re-enabled.
    task automatic idle(input logic [ACC_W-1:0] thr);
        enable    = 1'b0;
        valid_in  = 1'b0;
        thresh_in = thr;
        tick();
        check("thresh_tracks_when_disabled", 32'(thresh_cur), 32'(thr));
        enable = 1'b1;
    endtask

    // Runs n cycles (valid every cycle, or on even cycles if gapped) and
    // reports the 1-based cycle of the first strobe and the strobe count.
    task automatic run_n(input int n, input bit gapped, output int first, output int cnt);
        first = 0;
        cnt   = 0;
        for (int k = 0; k < n; k++) begin
            valid_in = gapped ? (k % 2 == 0) : 1'b1;
            tick();
            if (we_sum) begin
                cnt++;
                if (first == 0) first = k + 1;
            end
        end
        valid_in = 1'b0;
    endtask

    initial begin
        rf_resetn = 1'b0;
        enable    = 1'b0;
        decim     = '0;
        thresh_in = 12'd10;
        I_in      = '0;
        Q_in      = '0;
        valid_in  = 1'b0;
        tick();
        tick();
        check("reset_we", 32'(we_sum), 0);
        check("reset_sigmag", 32'({I_sum_sig, I_sum_mag, Q_sum_sig, Q_sum_mag}), 0);
        check("reset_thresh", 32'(thresh_cur), 1);
        rf_resetn = 1'b1;

        // Basic block: decim 4, +3 / -5 -> sums 12 / -20, thresh 10.
        idle(12'd10);
        decim = 5'd4; I_in = 8'sd3; Q_in = -8'sd5;
        run_n(4, 1'b0, first_idx, n_strobe);
        check("basic_first_strobe", 32'(first_idx), 4);
        check("basic_I", 32'({I_sum_sig, I_sum_mag}), 32'b01);
        check("basic_Q", 32'({Q_sum_sig, Q_sum_mag}), 32'b11);
        thresh_in = 12'd99;
        run_n(4, 1'b0, first_idx, n_strobe);
        check("basic_second_strobe", 32'(first_idx), 4);
        check("basic_strobe_count", 32'(n_strobe), 1);
        check("thresh_frozen_enabled", 32'(thresh_cur), 10);
        tick();
        check("hold_after_strobe", 32'({we_sum, I_sum_sig, I_sum_mag}), 32'b001);

        // Gapped valid: decim 3, +1 on alternate cycles, thresh 4 -> sum 3.
        idle(12'd4);
        decim = 5'd3; I_in = 8'sd1; Q_in = '0;
        run_n(12, 1'b1, first_idx, n_strobe);
        check("gapped_first_strobe", 32'(first_idx), 5);
        check("gapped_strobe_count", 32'(n_strobe), 2);
        check("gapped_I", 32'({I_sum_sig, I_sum_mag}), 32'b00);

        // decim 0 acts as 1: strobe every cycle.
        idle(12'd1);
        decim = 5'd0; I_in = 8'sd1; Q_in = 8'sd1;
        run_n(5, 1'b0, first_idx, n_strobe);
        check("decim0_first", 32'(first_idx), 1);
        check("decim0_count", 32'(n_strobe), 5);
        check("decim0_I", 32'({I_sum_sig, I_sum_mag}), 32'b01);

        // decim 16, -128 each -> -2048; magnitude 2048 >= 2047.
        idle(12'd2047);
        decim = 5'd16; I_in = 8'h80; Q_in = '0;
        run_n(16, 1'b0, first_idx, n_strobe);
        check("d16_first", 32'(first_idx), 16);
        check("d16_I", 32'({I_sum_sig, I_sum_mag}), 32'b11);
        check("d16_Q", 32'({Q_sum_sig, Q_sum_mag}), 32'b00);

        // decim 20 clamps to 16.
        idle(12'd16);
        decim = 5'd20; I_in = 8'sd1; Q_in = '0;
        run_n(20, 1'b0, first_idx, n_strobe);
        check("clamp_first", 32'(first_idx), 16);
        check("clamp_count", 32'(n_strobe), 1);
        check("clamp_I", 32'({I_sum_sig, I_sum_mag}), 32'b01);

        // Abort by disable: old 5 samples of +2 are discarded; 8 x +1 = 8 < 9.
        idle(12'd9);
        decim = 5'd8; I_in = 8'sd2; Q_in = '0;
        run_n(5, 1'b0, first_idx, n_strobe);
        check("abort_partial_none", 32'(n_strobe), 0);
        idle(12'd9);
        I_in = 8'sd1;
        run_n(10, 1'b0, first_idx, n_strobe);
        check("abort_first", 32'(first_idx), 8);
        check("abort_I", 32'({I_sum_sig, I_sum_mag}), 32'b00);

        // Abort by reset: outputs clear asynchronously, threshold returns to 1.
        idle(12'd1);
        decim = 5'd1; I_in = -8'sd1; Q_in = -8'sd1;
        run_n(1, 1'b0, first_idx, n_strobe);
        check("pre_reset_sigmag", 32'({I_sum_sig, I_sum_mag, Q_sum_sig, Q_sum_mag}), 32'b1111);
        thresh_in = 12'd7;
        decim = 5'd8; I_in = 8'sd1;
        run_n(5, 1'b0, first_idx, n_strobe);
        rf_resetn = 1'b0;
        #1;
        check("midreset_outputs", 32'({we_sum, I_sum_sig, I_sum_mag, Q_sum_sig, Q_sum_mag}), 0);
        check("midreset_thresh", 32'(thresh_cur), 1);
        tick();
        rf_resetn = 1'b1;
        run_n(10, 1'b0, first_idx, n_strobe);
        check("postreset_first", 32'(first_idx), 8);
        check("postreset_I", 32'({I_sum_sig, I_sum_mag}), 32'b01);
        check("postreset_thresh", 32'(thresh_cur), 1);

        // Mid-block decim change 4 -> 2: strobes after samples 4, 6, 8.
        idle(12'd1);
        decim = 5'd4; I_in = 8'sd1; Q_in = '0;
        run_n(2, 1'b0, first_idx, n_strobe);
        check("midchg_none_yet", 32'(n_strobe), 0);
        decim = 5'd2;
        run_n(6, 1'b0, first_idx, n_strobe);
        check("midchg_first", 32'(first_idx), 2);
        check("midchg_count", 32'(n_strobe), 3);

`ifdef ACQ_PRESUM_AGC_EN
        // AGC: +/-50 every result, threshold climbs 1 per 128-result window.
        idle(12'd1);
        decim = 5'd1;
        for (int w = 1; w <= 52; w++) begin
            for (int k = 0; k < 128; k++) begin
                I_in = (k % 2 == 0) ? 8'sd50 : -8'sd50;
                Q_in = I_in;
                valid_in = 1'b1;
                tick();
            end
            if (w == 1)  check("agc_win1", 32'(thresh_cur), 2);
            if (w == 50) check("agc_win50", 32'(thresh_cur), 51);
            if (w == 51) check("agc_win51", 32'(thresh_cur), 50);
            if (w == 52) check("agc_win52", 32'(thresh_cur), 51);
        end
        valid_in = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
